// File: rtl/pipe_skid_register_pkg.sv
// Shared types for the elastic pipeline stage register: state encoding and
// the occupancy decode used to register the occupancy output.
package pipe_skid_register_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_register.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Every output is a flop, so no combinational path crosses the stage.
module pipe_skid_register
  import pipe_skid_register_pkg::*;
#(
  parameter int unsigned          BUS_SIZE    = 32,
  parameter logic [BUS_SIZE-1:0]  RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [BUS_SIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BUS_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          occupancy
);

  state_e              state_q, state_d;
  logic [BUS_SIZE-1:0] main_q, main_d;
  logic [BUS_SIZE-1:0] skid_q, skid_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [1:0]          occ_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the skid beat always drains before new input.
        if (out_fire) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Bank contents are don't-care after a flush; only the state is forced.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: vector table, corner-case sequences, and
// randomized traffic against a queue-based model of the stage.
module tb_pipe_skid_register;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_register #(.BUS_SIZE(W), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         eov;
    logic [W-1:0] eod;
    logic         chkd;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  vec_t tbl[11];
  logic [W-1:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eov, input logic [W-1:0] eod,
                         input logic chkd, input logic eir, input logic [1:0] eocc);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, eir});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, eocc});
    if (chkd) chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, eod});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, RV, 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic stall;
    logic [W-1:0] prev_od;
    logic iv, ordy, fl, mr, inf, outf;
    logic [W-1:0] d;

    // stream 1..4 then drain; backpressure A,B,C
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 2'd1};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 2'd1};
    tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 2'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 2'd2};
    tbl[7]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk_all($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eod, tbl[i].chkd, tbl[i].eir, tbl[i].eocc);
    end

    // flush while FULL with a beat on offer
    apply(1'b1, 8'h10, 1'b0, 1'b0);
    apply(1'b1, 8'h11, 1'b0, 1'b0);
    chk_all("flush.pre", 1'b1, 8'h10, 1'b1, 1'b0, 2'd2);
    apply(1'b1, 8'h12, 1'b1, 1'b1);
    chk_all("flush.post", 1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      chk_all("flush.idle", 1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
    end

    // async reset while FULL, no clock edge
    apply(1'b1, 8'h21, 1'b0, 1'b0);
    apply(1'b1, 8'h22, 1'b0, 1'b0);
    chk_all("areset.pre", 1'b1, 8'h21, 1'b1, 1'b0, 2'd2);
    #2 rst = 1'b0;
    #1;
    chk_all("areset.async", 1'b0, RV, 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 8'h33, 1'b0, 1'b0);
    chk_all("areset.first", 1'b1, 8'h33, 1'b1, 1'b1, 2'd1);

    // randomized traffic, first 200 cycles alternate out_ready with in_valid held
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc < 200) begin
        iv = 1'b1; ordy = cyc[0]; fl = 1'b0;
      end else begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        fl   = ($urandom_range(0, 63) == 0);
      end
      d = W'($urandom);
      mr   = (q.size() < 2);
      inf  = iv & mr;
      outf = (q.size() > 0) & ordy;
      stall = (q.size() > 0) & !ordy & !fl;
      prev_od = (q.size() > 0) ? q[0] : '0;
      if (fl) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(d);
      end
      apply(iv, d, ordy, fl);
      chk_all("rand", q.size() > 0, (q.size() > 0) ? q[0] : '0, q.size() > 0,
              q.size() < 2, 2'(q.size()));
      if (stall) chk("rand.stall_stable", {24'd0, out_data}, {24'd0, prev_od});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
